if_id_stage: RTL and testbench

//  Fetch stage plus IF/ID pipeline register of the 5-stage pipeline. Holds the PC,

---
 rtl/if_id_stage.sv | 102 ++++++++++
 tb/tb_if_id_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register.
// Holds the PC, presents it as the instruction-memory address, and latches the
// fetched word into IF/ID. A branch redirect from EX beats a hazard stall, a
// stall beats an instruction-memory wait, and a wait beats a normal fetch.
// Every output is a register or a function of registers only.
module if_id_stage #(
  parameter int unsigned          PC_W        = 32,
  parameter logic [PC_W-1:0]      RESET_PC    = {PC_W{1'b0}},
  parameter logic [31:0]          NOP_WORD    = 32'h0000_0000,
  parameter int unsigned          STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stop,
  input  logic                    branch_taken,
  input  logic [PC_W-1:0]         branch_target,
  input  logic                    imem_ready,
  input  logic [31:0]             imem_data,
  output logic [PC_W-1:0]         imem_addr,
  output logic [PC_W-1:0]         pc_id,
  output logic [31:0]             instr_id,
  output logic                    valid_id,
  output logic [9:0]              hazard_fields,
  output logic [STALL_CNT_W-1:0]  stall_count
);

  logic [PC_W-1:0]        pc_r;
  logic [PC_W-1:0]        pc_id_r;
  logic [31:0]            instr_id_r;
  logic                   valid_id_r;
  logic [STALL_CNT_W-1:0] stall_count_r;

  logic [PC_W-1:0]        pc_nxt_s;
  logic [PC_W-1:0]        pc_id_nxt_s;
  logic [31:0]            instr_id_nxt_s;
  logic                   valid_id_nxt_s;
  logic [STALL_CNT_W-1:0] stall_count_nxt_s;

  // rs and rt of a MIPS-style instruction word, as compared by the hazard unit
  function automatic logic [9:0] rs_rt_of(input logic [31:0] word);
    return {word[25:21], word[20:16]};
  endfunction

  // Next-state selection in priority order: redirect, stall, memory wait, fetch
  always_comb begin
    pc_nxt_s          = pc_r;
    pc_id_nxt_s       = pc_id_r;
    instr_id_nxt_s    = instr_id_r;
    valid_id_nxt_s    = valid_id_r;
    stall_count_nxt_s = stall_count_r;
    if (branch_taken) begin
      // Redirect kills whatever sits in IF/ID, even a stalled instruction
      pc_nxt_s       = branch_target;
      pc_id_nxt_s    = {PC_W{1'b0}};
      instr_id_nxt_s = NOP_WORD;
      valid_id_nxt_s = 1'b0;
    end else if (stop) begin
      // PC and IF/ID hold; only the saturating stall counter moves
      if (stall_count_r != {STALL_CNT_W{1'b1}}) begin
        stall_count_nxt_s = stall_count_r + STALL_CNT_W'(1'b1);
      end else begin
        stall_count_nxt_s = stall_count_r;
      end
    end else if (!imem_ready) begin
      // Memory not ready: refetch the same PC, push a bubble downstream
      pc_id_nxt_s    = {PC_W{1'b0}};
      instr_id_nxt_s = NOP_WORD;
      valid_id_nxt_s = 1'b0;
    end else begin
      // Normal fetch; the PC wraps silently at the top of the address space
      pc_nxt_s       = pc_r + PC_W'(3'd4);
      pc_id_nxt_s    = pc_r;
      instr_id_nxt_s = imem_data;
      valid_id_nxt_s = 1'b1;
    end
  end

  // PC, IF/ID register and stall counter with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      pc_id_r       <= {PC_W{1'b0}};
      instr_id_r    <= NOP_WORD;
      valid_id_r    <= 1'b0;
      stall_count_r <= {STALL_CNT_W{1'b0}};
    end else begin
      pc_r          <= pc_nxt_s;
      pc_id_r       <= pc_id_nxt_s;
      instr_id_r    <= instr_id_nxt_s;
      valid_id_r    <= valid_id_nxt_s;
      stall_count_r <= stall_count_nxt_s;
    end
  end

  assign imem_addr     = pc_r;
  assign pc_id         = pc_id_r;
  assign instr_id      = instr_id_r;
  assign valid_id      = valid_id_r;
  assign hazard_fields = rs_rt_of(instr_id_r);
  assign stall_count   = stall_count_r;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized self-checking bench for if_id_stage.
// Two instances share one stimulus stream: a 32-bit PC / 16-bit counter build
// reset to 0x100, and an 8-bit PC / 2-bit counter build reset to 0xF0 so that
// address wrap and counter saturation are exercised. A per-instance reference
// model tracks PC, IF/ID contents and stall count by plain arithmetic.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic        stop;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;
  logic [31:0] imem_data;

  logic [31:0] imem_addr_a;
  logic [31:0] pc_id_a;
  logic [31:0] instr_id_a;
  logic        valid_id_a;
  logic [9:0]  hazard_fields_a;
  logic [15:0] stall_count_a;

  logic [7:0]  imem_addr_b;
  logic [7:0]  pc_id_b;
  logic [31:0] instr_id_b;
  logic        valid_id_b;
  logic [9:0]  hazard_fields_b;
  logic [1:0]  stall_count_b;

  int vectors;
  int miscompares;

  // Reference model state, one slot per instance
  logic [63:0] m_pc    [2];
  logic [63:0] m_pc_id [2];
  logic [31:0] m_instr [2];
  logic        m_valid [2];
  logic [63:0] m_cnt   [2];

  logic [63:0] pc_mod  [2] = '{64'h1_0000_0000, 64'h0000_0100};
  logic [63:0] cnt_max [2] = '{64'h0000_FFFF, 64'h0000_0003};
  logic [63:0] rst_pc  [2] = '{64'h0000_0100, 64'h0000_00F0};

  if_id_stage #(
    .PC_W(32), .RESET_PC(32'h0000_0100), .NOP_WORD(32'h0000_0000), .STALL_CNT_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .stop(stop), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_ready(imem_ready), .imem_data(imem_data),
    .imem_addr(imem_addr_a), .pc_id(pc_id_a), .instr_id(instr_id_a),
    .valid_id(valid_id_a), .hazard_fields(hazard_fields_a), .stall_count(stall_count_a)
  );

  if_id_stage #(
    .PC_W(8), .RESET_PC(8'hF0), .NOP_WORD(32'h0000_0000), .STALL_CNT_W(2)
  ) dut_b (
    .clk(clk), .reset(reset), .stop(stop), .branch_taken(branch_taken),
    .branch_target(branch_target[7:0]), .imem_ready(imem_ready), .imem_data(imem_data),
    .imem_addr(imem_addr_b), .pc_id(pc_id_b), .instr_id(instr_id_b),
    .valid_id(valid_id_b), .hazard_fields(hazard_fields_b), .stall_count(stall_count_b)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the applied inputs
  task automatic model_edge(input logic r, input logic br, input logic st, input logic rdy,
                            input logic [31:0] tgt, input logic [31:0] data);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_pc[i] = rst_pc[i]; m_pc_id[i] = 64'd0; m_instr[i] = 32'd0;
        m_valid[i] = 1'b0; m_cnt[i] = 64'd0;
      end else if (br) begin
        m_pc[i] = 64'(tgt) % pc_mod[i];
        m_pc_id[i] = 64'd0; m_instr[i] = 32'd0; m_valid[i] = 1'b0;
      end else if (st) begin
        if (m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 64'd1;
      end else if (!rdy) begin
        m_pc_id[i] = 64'd0; m_instr[i] = 32'd0; m_valid[i] = 1'b0;
      end else begin
        m_instr[i] = data; m_pc_id[i] = m_pc[i]; m_valid[i] = 1'b1;
        m_pc[i] = (m_pc[i] + 64'd4) % pc_mod[i];
      end
    end
  endtask

  task automatic check_all();
    check("a.imem_addr", 64'(imem_addr_a), m_pc[0]);
    check("a.pc_id",     64'(pc_id_a),     m_pc_id[0]);
    check("a.instr_id",  64'(instr_id_a),  64'(m_instr[0]));
    check("a.valid_id",  64'(valid_id_a),  64'(m_valid[0]));
    check("a.hazard",    64'(hazard_fields_a), 64'({m_instr[0][25:21], m_instr[0][20:16]}));
    check("a.stall_cnt", 64'(stall_count_a), m_cnt[0]);
    check("b.imem_addr", 64'(imem_addr_b), m_pc[1]);
    check("b.pc_id",     64'(pc_id_b),     m_pc_id[1]);
    check("b.instr_id",  64'(instr_id_b),  64'(m_instr[1]));
    check("b.valid_id",  64'(valid_id_b),  64'(m_valid[1]));
    check("b.hazard",    64'(hazard_fields_b), 64'({m_instr[1][25:21], m_instr[1][20:16]}));
    check("b.stall_cnt", 64'(stall_count_b), m_cnt[1]);
  endtask

  // Apply one cycle of inputs, let the edge happen, then compare away from it
  task automatic step(input logic r, input logic br, input logic st, input logic rdy,
                      input logic [31:0] tgt, input logic [31:0] data);
    reset = r; branch_taken = br; stop = st; imem_ready = rdy;
    branch_target = tgt; imem_data = data;
    @(posedge clk);
    model_edge(r, br, st, rdy, tgt, data);
    #1;
    check_all();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; stop = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    imem_ready = 1'b1; imem_data = 32'd0;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 64'd0; m_pc_id[i] = 64'd0; m_instr[i] = 32'd0;
      m_valid[i] = 1'b0; m_cnt[i] = 64'd0;
    end

    // Reset and sequential fetch from 0x100
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'hDEAD_0000);
    check("rst.addr", 64'(imem_addr_a), 64'h100);
    check("rst.instr", 64'(instr_id_a), 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h1111_0000);
    check("w0.pc_id", 64'(pc_id_a), 64'h100);
    check("w0.valid", 64'(valid_id_a), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h2222_0004);

    // Two stall cycles hold W1 at 0x104; fetch resumes at 0x108
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'hBAD0_0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'hBAD0_0001);
    check("stall.addr", 64'(imem_addr_a), 64'h108);
    check("stall.pc_id", 64'(pc_id_a), 64'h104);
    check("stall.count", 64'(stall_count_a), 64'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h3333_0008);
    check("resume.pc_id", 64'(pc_id_a), 64'h108);

    // Memory wait at 0x10C for three cycles, then lw rs=9 rt=10 arrives
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'hBAD1_0000);
      check("wait.addr", 64'(imem_addr_a), 64'h10C);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h8D2A_0004);
    check("lw.pc_id", 64'(pc_id_a), 64'h10C);
    check("lw.hazard", 64'(hazard_fields_a), 64'(10'b01001_01010));
    check("wrap.addr8", 64'(imem_addr_b), 64'h00);

    // Redirect together with stall: redirect wins, counter untouched
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'hBAD2_0000);
    check("br.addr", 64'(imem_addr_a), 64'h200);
    check("br.valid", 64'(valid_id_a), 64'd0);
    check("br.count", 64'(stall_count_a), 64'd2);

    // Five more stalls: narrow counter saturates at 3
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'hBAD3_0000);
    check("sat.count2", 64'(stall_count_b), 64'd3);
    check("sat.count16", 64'(stall_count_a), 64'd7);

    // Reset asserted in the middle of a stall
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'hBAD4_0000);
    check("rststall.count", 64'(stall_count_a), 64'd0);
    check("rststall.addr8", 64'(imem_addr_b), 64'hF0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, br, st, rdy;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 99) == 0);
      br  = ($urandom_range(0, 99) < 8);
      st  = ($urandom_range(0, 99) < 25);
      rdy = ($urandom_range(0, 99) < 80);
      tgt = $urandom & 32'hFFFF_FFFC;
      step(r, br, st, rdy, tgt, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
